// File: rtl/cache_pkg.sv
// Shared definitions for the read-only 2-way instruction cache.
// Holds the address field widths, line geometry, bus request tag
// encoding and the miss-handling FSM state type.
package cache_pkg;

    localparam int ADDR_W    = 64;
    localparam int BUS_W     = 64;
    localparam int BUS_TAG_W = 13;
    localparam int WORD_W    = 32;

    // Address split: [tag | index | offset]
    localparam int OFFSET_W = 6;
    localparam int INDEX_W  = 6;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WSEL_W   = OFFSET_W - 2;

    // A line is eight bus beats; beat 0 sits in the lowest bits.
    localparam int BEATS  = 8;
    localparam int LINE_W = BUS_W * BEATS;

    // Bus request tag: {read, type, reserved}
    localparam logic                 REQ_READ        = 1'b1;
    localparam logic [3:0]           REQ_TYPE_MEMORY = 4'b0001;
    localparam logic [BUS_TAG_W-1:0] READ_MEM_TAG    = {REQ_READ, REQ_TYPE_MEMORY, 8'h00};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        REQ  = 2'd2,
        RESP = 2'd3
    } state_e;

endpackage

// File: rtl/cache_way.sv
// One way of the cache: valid bits, tag store and line store.
// Ports:
//   clk, reset            clock, synchronous active-high reset (clears valid bits)
//   lk_index/lk_tag/lk_word   lookup address fields
//   lk_hit, lk_data       combinational hit and selected 32-bit word
//   fill_index            set being filled; fill_valid reports its valid bit
//   wr_en, wr_tag, wr_line    whole-line synchronous write, sets valid
module cache_way
    import cache_pkg::*;
#(
    parameter int NUM_SETS = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] lk_index,
    input  logic [TAG_W-1:0]   lk_tag,
    input  logic [WSEL_W-1:0]  lk_word,
    output logic               lk_hit,
    output logic [WORD_W-1:0]  lk_data,
    input  logic [INDEX_W-1:0] fill_index,
    output logic               fill_valid,
    input  logic               wr_en,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [LINE_W-1:0]  wr_line
);

    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
    logic [LINE_W-1:0]   data_mem [NUM_SETS];
    logic [LINE_W-1:0]   lk_line;

    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[fill_index] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data stores are plain memories; only the valid bits need reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[fill_index]  <= wr_tag;
            data_mem[fill_index] <= wr_line;
        end
    end

    assign lk_line    = data_mem[lk_index];
    assign lk_hit     = valid_q[lk_index] && (tag_mem[lk_index] == lk_tag);
    assign lk_data    = lk_line[lk_word*WORD_W +: WORD_W];
    assign fill_valid = valid_q[fill_index];

endmodule

// File: rtl/set_assoc_cache.sv
// Read-only 2-way set-associative instruction cache with a combinational
// hit path and an 8-beat line fill over the shared address/data bus.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   addr, rd_wr_evict_flag     fetch address and request type (1 = read)
//   read_data, data_available  hit word and hit flag (same cycle)
//   bus_*                      request/response bus towards memory
//   addr_data_abtr_*           address/data bus arbitration
//   store_data_*               store path, unused and tied off
//   addr_data_bus_busy         cache owns the address/data bus
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = 64,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int BUS_DATA_WIDTH    = 64,
    parameter int BUS_TAG_WIDTH     = 13,
    parameter int NUM_SETS          = 64,
    parameter int NUM_WAYS          = 2,
    parameter int LINE_BYTES        = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDRESS_WIDTH-1:0]     addr,
    input  logic [1:0]                   rd_wr_evict_flag,
    output logic [INSTRUCTION_WIDTH-1:0] read_data,
    output logic                         data_available,
    output logic                         bus_reqcyc,
    output logic                         bus_respack,
    output logic [BUS_DATA_WIDTH-1:0]    bus_req,
    output logic [BUS_TAG_WIDTH-1:0]     bus_reqtag,
    input  logic                         bus_respcyc,
    input  logic                         bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0]    bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]     bus_resptag,
    input  logic                         addr_data_abtr_grant,
    output logic                         addr_data_abtr_reqcyc,
    input  logic                         store_data_abtr_grant,
    output logic                         store_data_abtr_reqcyc,
    output logic                         store_data_bus_busy,
    output logic                         addr_data_bus_busy
);

    localparam int NUM_BEATS = (LINE_BYTES * 8) / BUS_DATA_WIDTH;
    localparam int CNT_W     = $clog2(NUM_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] miss_addr_q, miss_addr_d;
    logic [LINE_W-1:0]        line_q, line_d;
    logic [NUM_SETS-1:0]      lru_q, lru_d;

    logic [INDEX_W-1:0] lk_index, fill_index;
    logic [TAG_W-1:0]   lk_tag, fill_tag;
    logic [WSEL_W-1:0]  lk_word;

    logic [NUM_WAYS-1:0] way_hit, way_fill_valid, way_wr_en;
    logic [WORD_W-1:0]   way_data [NUM_WAYS];

    logic req_rd, hit, hit_way, victim_way, fill_en;

    assign lk_word    = addr[OFFSET_W-1:2];
    assign lk_index   = addr[OFFSET_W +: INDEX_W];
    assign lk_tag     = addr[ADDRESS_WIDTH-1 -: TAG_W];
    assign fill_index = miss_addr_q[OFFSET_W +: INDEX_W];
    assign fill_tag   = miss_addr_q[ADDRESS_WIDTH-1 -: TAG_W];

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        assign way_wr_en[w] = fill_en && (victim_way == 1'(w));
        cache_way #(.NUM_SETS(NUM_SETS)) u_way (
            .clk        (clk),
            .reset      (reset),
            .lk_index   (lk_index),
            .lk_tag     (lk_tag),
            .lk_word    (lk_word),
            .lk_hit     (way_hit[w]),
            .lk_data    (way_data[w]),
            .fill_index (fill_index),
            .fill_valid (way_fill_valid[w]),
            .wr_en      (way_wr_en[w]),
            .wr_tag     (fill_tag),
            .wr_line    (line_d)
        );
    end

    assign req_rd  = (rd_wr_evict_flag == 2'd1);
    // A hit is only reported while idle so a line never reads half-filled.
    assign hit     = req_rd && (state_q == IDLE) && (|way_hit);
    assign hit_way = way_hit[1];

    // Fill the first invalid way, otherwise the least-recently-used one.
    assign victim_way = !way_fill_valid[0] ? 1'b0 :
                        !way_fill_valid[1] ? 1'b1 : lru_q[fill_index];

    assign data_available = hit;
    assign read_data      = hit ? way_data[hit_way] : '0;

    assign store_data_abtr_reqcyc = 1'b0;
    assign store_data_bus_busy    = 1'b0;

    // Bus handshake: a request is transferred in the cycle bus_reqcyc and
    // bus_reqack are both high; a response beat is transferred in each
    // cycle bus_respcyc is high while in RESP, and bus_respack echoes it
    // combinationally in that same cycle.
    always_comb begin
        state_d               = state_q;
        cnt_d                 = cnt_q;
        miss_addr_d           = miss_addr_q;
        line_d                = line_q;
        lru_d                 = lru_q;
        fill_en               = 1'b0;
        bus_reqcyc            = 1'b0;
        bus_respack           = 1'b0;
        bus_req               = '0;
        bus_reqtag            = '0;
        addr_data_abtr_reqcyc = 1'b0;
        addr_data_bus_busy    = 1'b0;

        if (hit) begin
            lru_d[lk_index] = ~hit_way;
        end

        case (state_q)
            IDLE: begin
                if (req_rd && !(|way_hit)) begin
                    miss_addr_d = {addr[ADDRESS_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    state_d     = ARB;
                end
            end
            ARB: begin
                addr_data_abtr_reqcyc = 1'b1;
                if (addr_data_abtr_grant) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                addr_data_abtr_reqcyc = 1'b1;
                addr_data_bus_busy    = 1'b1;
                bus_reqcyc            = 1'b1;
                bus_req               = miss_addr_q;
                bus_reqtag            = READ_MEM_TAG;
                cnt_d                 = '0;
                if (bus_reqack) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                addr_data_abtr_reqcyc = 1'b1;
                addr_data_bus_busy    = 1'b1;
                if (bus_respcyc) begin
                    bus_respack = 1'b1;
                    line_d[cnt_q*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = bus_resp;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        // line_d already carries the final beat, so the way
                        // write sees the complete line this cycle.
                        fill_en           = 1'b1;
                        lru_d[fill_index] = ~victim_way;
                        cnt_d             = '0;
                        state_d           = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            miss_addr_q <= '0;
            line_q      <= '0;
            lru_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            miss_addr_q <= miss_addr_d;
            line_q      <= line_d;
            lru_q       <= lru_d;
        end
    end

    // Response tag, store grant and the byte-in-word bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, bus_resptag, store_data_abtr_grant, addr[1:0]};

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed self-checking bench for set_assoc_cache.
module tb_set_assoc_cache;

    logic        clk;
    logic        reset;
    logic [63:0] addr;
    logic [1:0]  rd_wr_evict_flag;
    logic [31:0] read_data;
    logic        data_available;
    logic        bus_reqcyc;
    logic        bus_respack;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_respcyc;
    logic        bus_reqack;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        addr_data_abtr_grant;
    logic        addr_data_abtr_reqcyc;
    logic        store_data_abtr_grant;
    logic        store_data_abtr_reqcyc;
    logic        store_data_bus_busy;
    logic        addr_data_bus_busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    set_assoc_cache dut (
        .clk                    (clk),
        .reset                  (reset),
        .addr                   (addr),
        .rd_wr_evict_flag       (rd_wr_evict_flag),
        .read_data              (read_data),
        .data_available         (data_available),
        .bus_reqcyc             (bus_reqcyc),
        .bus_respack            (bus_respack),
        .bus_req                (bus_req),
        .bus_reqtag             (bus_reqtag),
        .bus_respcyc            (bus_respcyc),
        .bus_reqack             (bus_reqack),
        .bus_resp               (bus_resp),
        .bus_resptag            (bus_resptag),
        .addr_data_abtr_grant   (addr_data_abtr_grant),
        .addr_data_abtr_reqcyc  (addr_data_abtr_reqcyc),
        .store_data_abtr_grant  (store_data_abtr_grant),
        .store_data_abtr_reqcyc (store_data_abtr_reqcyc),
        .store_data_bus_busy    (store_data_bus_busy),
        .addr_data_bus_busy     (addr_data_bus_busy)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Beat i of a line with the given base: high word base+i+1, low word base+i+10.
    function automatic logic [63:0] beat(input logic [31:0] base, input int i);
        return {base + 32'(i + 1), base + 32'(i + 10)};
    endfunction

    // Reference word for byte address a in a line filled with the given base.
    function automatic logic [31:0] model_word(input logic [31:0] base, input logic [63:0] a);
        int w;
        int i;
        w = int'(a[5:2]);
        i = w / 2;
        return (w % 2 == 1) ? base + 32'(i + 1) : base + 32'(i + 10);
    endfunction

    // ---------------- drivers ----------------
    task automatic idle_inputs();
        rd_wr_evict_flag     = 2'd0;
        bus_respcyc          = 1'b0;
        bus_reqack           = 1'b0;
        bus_resp             = '0;
        addr_data_abtr_grant = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_da"},    {63'd0, data_available}, 64'd0);
        check({tag, "_rd"},    {32'd0, read_data}, 64'd0);
        check({tag, "_rcyc"},  {63'd0, bus_reqcyc}, 64'd0);
        check({tag, "_rack"},  {63'd0, bus_respack}, 64'd0);
        check({tag, "_breq"},  bus_req, 64'd0);
        check({tag, "_btag"},  {51'd0, bus_reqtag}, 64'd0);
        check({tag, "_arb"},   {63'd0, addr_data_abtr_reqcyc}, 64'd0);
        check({tag, "_busy"},  {63'd0, addr_data_bus_busy}, 64'd0);
        check({tag, "_sarb"},  {63'd0, store_data_abtr_reqcyc}, 64'd0);
        check({tag, "_sbusy"}, {63'd0, store_data_bus_busy}, 64'd0);
    endtask

    // Caller has already presented the missing addr with flag=1 at a negedge.
    task automatic serve_miss(input logic [63:0] line_addr, input int grant_dly,
                              input int ack_dly, input int gap, input logic [31:0] base,
                              input int n_beats, input logic [63:0] mid_addr);
        #1;
        check("miss_da", {63'd0, data_available}, 64'd0);
        @(negedge clk);
        check("arb_req", {63'd0, addr_data_abtr_reqcyc}, 64'd1);
        check("arb_busy", {63'd0, addr_data_bus_busy}, 64'd0);
        for (int k = 0; k < grant_dly; k++) begin
            @(negedge clk);
            check("arb_wait", {63'd0, addr_data_abtr_reqcyc}, 64'd1);
            check("arb_wait_rcyc", {63'd0, bus_reqcyc}, 64'd0);
        end
        addr_data_abtr_grant = 1'b1;
        @(negedge clk);
        addr_data_abtr_grant = 1'b0;
        check("req_cyc", {63'd0, bus_reqcyc}, 64'd1);
        check("req_addr", bus_req, line_addr);
        check("req_tag", {51'd0, bus_reqtag}, 64'h1100);
        check("req_busy", {63'd0, addr_data_bus_busy}, 64'd1);
        for (int k = 0; k < ack_dly; k++) begin
            @(negedge clk);
            check("req_hold", {63'd0, bus_reqcyc}, 64'd1);
        end
        bus_reqack = 1'b1;
        @(negedge clk);
        bus_reqack = 1'b0;
        check("resp_rcyc", {63'd0, bus_reqcyc}, 64'd0);
        check("resp_busy", {63'd0, addr_data_bus_busy}, 64'd1);
        check("resp_arb", {63'd0, addr_data_abtr_reqcyc}, 64'd1);
        for (int i = 0; i < n_beats; i++) begin
            for (int g = 0; g < gap; g++) begin
                bus_respcyc = 1'b0;
                #1;
                check("gap_ack", {63'd0, bus_respack}, 64'd0);
                @(negedge clk);
            end
            if (i == 4 && mid_addr != 64'd0) addr = mid_addr;
            bus_respcyc = 1'b1;
            bus_resp    = beat(base, i);
            #1;
            check("beat_ack", {63'd0, bus_respack}, 64'd1);
            check("fill_da", {63'd0, data_available}, 64'd0);
            @(negedge clk);
        end
        bus_respcyc = 1'b0;
        bus_resp    = '0;
    endtask

    // Expect a hit for address a, whose line was filled with the given base.
    task automatic expect_hit(input string tag, input logic [63:0] a, input logic [31:0] base);
        logic [31:0] exp;
        addr             = a;
        rd_wr_evict_flag = 2'd1;
        exp_q.push_back(model_word(base, a));
        #1;
        exp = exp_q.pop_front();
        check({tag, "_da"}, {63'd0, data_available}, 64'd1);
        check({tag, "_rd"}, {32'd0, read_data}, {32'd0, exp});
        @(negedge clk);
        check({tag, "_noarb"}, {63'd0, addr_data_abtr_reqcyc}, 64'd0);
    endtask

    // Expect a miss for address a; the flag is withdrawn before the edge.
    task automatic expect_miss(input string tag, input logic [63:0] a);
        addr             = a;
        rd_wr_evict_flag = 2'd1;
        #1;
        check({tag, "_da"}, {63'd0, data_available}, 64'd0);
        check({tag, "_rd"}, {32'd0, read_data}, 64'd0);
        rd_wr_evict_flag = 2'd0;
        @(negedge clk);
    endtask

    // ---------------- sequence ----------------
    initial begin
        reset                 = 1'b1;
        addr                  = '0;
        bus_resptag           = '0;
        store_data_abtr_grant = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_outputs_zero("reset");
        @(negedge clk);

        // First miss: no stalls, line at 0x1000 with base 0.
        addr             = 64'h1000;
        rd_wr_evict_flag = 2'd1;
        serve_miss(64'h1000, 0, 0, 0, 32'h0, 8, 64'd0);
        check("post_fill_arb", {63'd0, addr_data_abtr_reqcyc}, 64'd0);
        expect_hit("hit_1004", 64'h1004, 32'h0);
        expect_hit("hit_1038", 64'h1038, 32'h0);
        expect_hit("hit_1000", 64'h1000, 32'h0);

        // Same index, second way, with grant/ack stalls and beat gaps.
        addr = 64'h2000;
        serve_miss(64'h2000, 5, 3, 2, 32'h100, 8, 64'd0);
        expect_hit("hit_2008", 64'h2008, 32'h100);
        expect_hit("hit_1004b", 64'h1004, 32'h0);
        expect_hit("hit_203c", 64'h203c, 32'h100);

        // 0x2000 touched last -> 0x3000 evicts 0x1000.
        addr = 64'h3000;
        serve_miss(64'h3000, 1, 0, 1, 32'h200, 8, 64'd0);
        expect_hit("hit_3004", 64'h3004, 32'h200);
        expect_hit("keep_2000", 64'h2000, 32'h100);
        expect_miss("evict_1000", 64'h1000);
        check("evict_noarb", {63'd0, addr_data_abtr_reqcyc}, 64'd0);

        // No request for flag values other than 1.
        addr             = 64'h9000;
        rd_wr_evict_flag = 2'd0;
        #1;
        check("flag0_da", {63'd0, data_available}, 64'd0);
        @(negedge clk);
        check("flag0_arb", {63'd0, addr_data_abtr_reqcyc}, 64'd0);
        addr             = 64'h2000;
        rd_wr_evict_flag = 2'd2;
        #1;
        check("flag2_da", {63'd0, data_available}, 64'd0);
        check("flag2_rd", {32'd0, read_data}, 64'd0);
        @(negedge clk);
        check("flag2_arb", {63'd0, addr_data_abtr_reqcyc}, 64'd0);

        // Response beats outside RESP are not acknowledged.
        rd_wr_evict_flag = 2'd0;
        bus_respcyc      = 1'b1;
        bus_resp         = 64'hdead_beef_0bad_f00d;
        #1;
        check("stray_ack", {63'd0, bus_respack}, 64'd0);
        @(negedge clk);
        bus_respcyc = 1'b0;

        // Address changes mid-fill: fill completes for 0x4040, then 0x2004 hits.
        addr             = 64'h4040;
        rd_wr_evict_flag = 2'd1;
        serve_miss(64'h4040, 1, 1, 1, 32'h300, 8, 64'h2004);
        expect_hit("mid_2004", 64'h2004, 32'h100);
        expect_hit("mid_407c", 64'h407c, 32'h300);

        // Reset in the middle of a fill.
        addr             = 64'h5080;
        rd_wr_evict_flag = 2'd1;
        serve_miss(64'h5080, 0, 0, 0, 32'h400, 3, 64'd0);
        reset            = 1'b1;
        rd_wr_evict_flag = 2'd0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        @(negedge clk);
        expect_miss("rst_inval_2000", 64'h2000);
        expect_miss("rst_inval_3004", 64'h3004);
        addr             = 64'h2000;
        rd_wr_evict_flag = 2'd1;
        @(negedge clk);
        check("rst_rearb", {63'd0, addr_data_abtr_reqcyc}, 64'd1);
        rd_wr_evict_flag = 2'd0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
